// File: rtl/elevator_scheduler.sv
// Three-floor elevator request scheduler.
// Latches cab/hall buttons into per-floor pending bits, picks the next floor
// in the current sweep direction, and drives a held one-hot floor command to
// the car FSM. If the car never reports busy, the command is retried.
module elevator_scheduler #(
    parameter int HOLD_CYC = 4,
    parameter int BUSY_TO  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req_in,
    input  logic [1:0] floor,
    input  logic       busy,
    output logic [5:0] cmd,
    output logic [2:0] pending,
    output logic       cur_dir
);

    // One counter covers both the command hold time and the busy timeout.
    localparam int MAX_CYC = (HOLD_CYC > BUSY_TO) ? HOLD_CYC : BUSY_TO;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(BUSY_TO - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT_BUSY,
        RUN,
        ARRIVE
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      pend_reg, pend_next;
    logic [2:0]      tgt_reg, tgt_next;
    logic            dir_reg, dir_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic [2:0]      set_vec;
    logic [2:0]      clr_vec;
    logic [2:0]      here;
    logic [2:0]      above;
    logic [2:0]      below;
    logic [2:0]      up_pick;
    logic [2:0]      dn_pick;
    logic [2:0]      pick;
    logic            pick_flip;
    logic            floor_ok;
    logic            pend_here;

    // floor == 3 is not a real position: nothing is cleared or chosen from it.
    assign floor_ok  = (floor != 2'd3);
    assign pend_here = |(pend_reg & here);

    // Per-floor decode: button merge, current-floor mask, and floors above/below the car.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_floor
            localparam logic [1:0] FL = 2'(gi);
            assign set_vec[gi] = req_in[gi] | req_in[gi+3];
            assign here[gi]    = (floor == FL);
            assign above[gi]   = pend_reg[gi] & floor_ok & (floor < FL);
            assign below[gi]   = pend_reg[gi] & floor_ok & (floor > FL);
        end
    endgenerate

    // Nearest pending floor in each direction, then the sweep-direction choice.
    always_comb begin
        up_pick   = above & (~above + 3'd1);
        dn_pick   = 3'b000;
        if (below[2])      dn_pick = 3'b100;
        else if (below[1]) dn_pick = 3'b010;
        else if (below[0]) dn_pick = 3'b001;

        pick      = 3'b000;
        pick_flip = 1'b0;
        if (dir_reg) begin
            if (up_pick != 3'b000) begin
                pick = up_pick;
            end else begin
                pick      = dn_pick;
                pick_flip = (dn_pick != 3'b000);
            end
        end else begin
            if (dn_pick != 3'b000) begin
                pick = dn_pick;
            end else begin
                pick      = up_pick;
                pick_flip = (up_pick != 3'b000);
            end
        end
    end

    // Scheduler next-state logic; a new request always wins over a same-cycle clear.
    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        dir_next   = dir_reg;
        cnt_next   = cnt_reg;
        clr_vec    = 3'b000;

        case (state_reg)
            IDLE: begin
                if (pend_reg != 3'b000) state_next = SELECT;
            end
            SELECT: begin
                if (floor_ok) begin
                    if (pend_here && !busy) begin
                        // Car already stopped here: serve without a command.
                        clr_vec    = here;
                        state_next = IDLE;
                    end else if (pick != 3'b000) begin
                        tgt_next   = pick;
                        dir_next   = pick_flip ? ~dir_reg : dir_reg;
                        cnt_next   = HOLD_LOAD;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            ISSUE: begin
                if (cnt_reg == '0) begin
                    cnt_next   = WAIT_LOAD;
                    state_next = WAIT_BUSY;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else if (cnt_reg == '0) begin
                    // Car ignored the command: pick again with pend untouched.
                    cnt_next   = '0;
                    state_next = SELECT;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RUN: begin
                if (!busy) begin
                    cnt_next   = '0;
                    state_next = ARRIVE;
                end
            end
            ARRIVE: begin
                if (floor_ok) begin
                    clr_vec    = here;
                    state_next = (((pend_reg & ~here) | set_vec) != 3'b000) ? SELECT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pend_next = (pend_reg & ~clr_vec) | set_vec;
    end

    // State, request latch, target, direction and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            pend_reg  <= 3'b000;
            tgt_reg   <= 3'b000;
            dir_reg   <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            tgt_reg   <= tgt_next;
            dir_reg   <= dir_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Command exists only while issuing, so reset removes it immediately.
    assign cmd     = {3'b000, (state_reg == ISSUE) ? tgt_reg : 3'b000};
    assign pending = pend_reg;
    assign cur_dir = dir_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: a per-cycle reference model
// plus directed scenarios with hand-computed expectations.
module tb_elevator_scheduler;

    localparam int HOLD = 4;
    localparam int BTO  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] req_in = 6'b0;
    logic [1:0] floor = 2'd0;
    logic       busy = 1'b0;
    logic [5:0] cmd;
    logic [2:0] pending;
    logic       cur_dir;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(.HOLD_CYC(HOLD), .BUSY_TO(BTO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .floor   (floor),
        .busy    (busy),
        .cmd     (cmd),
        .pending (pending),
        .cur_dir (cur_dir)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 choosing, 2 commanding, 3 awaiting busy, 4 moving, 5 arrived.
    int         m_ph, n_ph, m_tgt, n_tgt, m_timer, n_tm, clr_f, t, fl;
    logic [2:0] m_pend, n_pend, set_v;
    logic       m_dir, n_dir;
    logic [5:0] exp_cmd;

    always_comb begin
        n_ph   = m_ph;
        n_tgt  = m_tgt;
        n_dir  = m_dir;
        n_tm   = m_timer;
        clr_f  = -1;
        t      = -1;
        fl     = int'(floor);
        set_v  = req_in[2:0] | req_in[5:3];
        case (m_ph)
            0: if (m_pend != 3'b000) n_ph = 1;
            1: if (fl != 3) begin
                if (m_pend[fl] && !busy) begin
                    clr_f = fl;
                    n_ph  = 0;
                end else begin
                    if (m_dir) begin
                        for (int i = fl + 1; i <= 2; i++) if (t < 0 && m_pend[i]) t = i;
                        if (t < 0) begin
                            for (int i = fl - 1; i >= 0; i--) if (t < 0 && m_pend[i]) t = i;
                            if (t >= 0) n_dir = 1'b0;
                        end
                    end else begin
                        for (int i = fl - 1; i >= 0; i--) if (t < 0 && m_pend[i]) t = i;
                        if (t < 0) begin
                            for (int i = fl + 1; i <= 2; i++) if (t < 0 && m_pend[i]) t = i;
                            if (t >= 0) n_dir = 1'b1;
                        end
                    end
                    if (t >= 0) begin
                        n_tgt = t;
                        n_ph  = 2;
                        n_tm  = HOLD;
                    end else begin
                        n_ph = 0;
                    end
                end
            end
            2: begin
                n_tm = m_timer - 1;
                if (n_tm == 0) begin
                    n_ph = 3;
                    n_tm = BTO;
                end
            end
            3: if (busy) n_ph = 4;
               else begin
                   n_tm = m_timer - 1;
                   if (n_tm == 0) n_ph = 1;
               end
            4: if (!busy) n_ph = 5;
            5: if (fl != 3) begin
                clr_f = fl;
                n_ph  = (((m_pend & ~(3'b001 << fl)) | set_v) != 3'b000) ? 1 : 0;
            end
            default: n_ph = 0;
        endcase
        n_pend = m_pend;
        if (clr_f >= 0) n_pend = n_pend & ~(3'b001 << clr_f);
        n_pend = n_pend | set_v;
        exp_cmd = (m_ph == 2) ? 6'(1 << m_tgt) : 6'd0;
    end

    // Model state update, reset asynchronously like the car controller.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph    <= 0;
            m_pend  <= 3'b000;
            m_tgt   <= 0;
            m_timer <= 0;
            m_dir   <= 1'b1;
        end else begin
            m_ph    <= n_ph;
            m_pend  <= n_pend;
            m_tgt   <= n_tgt;
            m_timer <= n_tm;
            m_dir   <= n_dir;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_cmd", 32'(cmd), 32'(exp_cmd));
            chk("cyc_pending", 32'(pending), 32'(m_pend));
            chk("cyc_dir", 32'(cur_dir), 32'(m_dir));
        end
    end

    // Wait (bounded) until a floor command appears.
    task automatic wait_cmd(input int lim);
        int n;
        n = 0;
        while (cmd == 6'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (cmd == 6'b0) begin
            checks++;
            $display("FAIL wait_cmd: no command after %0d cycles, got 0 required nonzero", lim);
        end
    endtask

    // Drive busy for a while, then report arrival at floor f.
    task automatic serve(input logic [1:0] f);
        busy = 1'b1;
        repeat (8) @(negedge clk);
        floor = f;
        busy  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        #7;
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_dir", 32'(cur_dir), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single 3F request from 1F: 2-cycle latency, 4-cycle hold
        req_in = 6'b000100;
        @(negedge clk);
        req_in = 6'b0;
        chk("s029_pending", 32'(pending), 'h4);
        chk("s029_cmd_e0", 32'(cmd), 0);
        @(negedge clk);
        chk("s029_cmd_sel", 32'(cmd), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s029_cmd_hold", 32'(cmd), 'h4);
        end
        @(negedge clk);
        chk("s029_cmd_rel", 32'(cmd), 0);
        $display("txn 029: 3F request issued and released");

        // Car runs 20 cycles then arrives at 3F
        busy = 1'b1;
        repeat (20) @(negedge clk);
        floor = 2'd2;
        busy  = 1'b0;
        @(negedge clk);
        chk("s030_arrive_pending", 32'(pending), 'h4);
        @(negedge clk);
        chk("s030_cleared", 32'(pending), 0);
        repeat (3) @(negedge clk);
        chk("s030_idle_cmd", 32'(cmd), 0);
        $display("txn 030: arrival at 3F clears pending");

        // From 2F going up: 3F first, then 1F after direction flip
        floor  = 2'd1;
        req_in = 6'b000101;
        @(negedge clk);
        req_in = 6'b0;
        chk("s031_pending", 32'(pending), 'h5);
        wait_cmd(10);
        chk("s031_first", 32'(cmd), 'h4);
        chk("s031_dir_up", 32'(cur_dir), 1);
        serve(2'd2);
        wait_cmd(20);
        chk("s031_second", 32'(cmd), 'h1);
        chk("s031_dir_down", 32'(cur_dir), 0);
        chk("s031_left", 32'(pending), 'h1);
        serve(2'd0);
        repeat (3) @(negedge clk);
        chk("s031_done", 32'(pending), 0);
        $display("txn 031: 3F then 1F served with direction flip");

        // Hall call at the floor the car is parked on
        req_in = 6'b001000;
        @(negedge clk);
        req_in = 6'b0;
        chk("s032_set", 32'(pending), 'h1);
        @(negedge clk);
        chk("s032_select", 32'(pending), 'h1);
        @(negedge clk);
        chk("s032_clear", 32'(pending), 0);
        chk("s032_cmd", 32'(cmd), 0);
        $display("txn 032: same-floor call cleared without command");

        // Illegal floor stalls selection until the position is valid
        floor  = 2'd3;
        req_in = 6'b000001;
        @(negedge clk);
        req_in = 6'b0;
        repeat (5) @(negedge clk);
        chk("s021_stall_pend", 32'(pending), 'h1);
        chk("s021_stall_cmd", 32'(cmd), 0);
        floor = 2'd0;
        repeat (2) @(negedge clk);
        chk("s021_release", 32'(pending), 0);
        $display("txn 021: floor=3 stall then clear");

        // 2F issued, car never goes busy: retry after 4 + 16 + 1 cycles
        req_in = 6'b000010;
        @(negedge clk);
        req_in = 6'b0;
        wait_cmd(10);
        chk("s033_first", 32'(cmd), 'h2);
        chk("s033_dir", 32'(cur_dir), 1);
        n = 0;
        while (cmd != 6'b0 && n < 50) begin @(negedge clk); n++; end
        while (cmd == 6'b0 && n < 50) begin @(negedge clk); n++; end
        chk("s033_retry_gap", 32'(n), 21);
        chk("s033_retry_cmd", 32'(cmd), 'h2);
        chk("s033_still_pend", 32'(pending), 'h2);
        $display("txn 033: 2F retried after timeout, gap %0d", n);

        // Reset in the middle of ISSUE, between clock edges
        #3;
        rst = 1'b0;
        #1;
        chk("s034_async_cmd", 32'(cmd), 0);
        chk("s034_async_pend", 32'(pending), 0);
        chk("s034_async_dir", 32'(cur_dir), 1);
        req_in = 6'b000100;
        @(posedge clk);
        #1;
        chk("s034_held_in_rst", 32'(pending), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("s028_latch_on_release", 32'(pending), 'h4);
        req_in = 6'b0;
        wait_cmd(10);
        chk("s028_cmd", 32'(cmd), 'h4);
        serve(2'd2);
        repeat (3) @(negedge clk);
        chk("s028_done", 32'(pending), 0);
        $display("txn 034a: async reset mid-issue, request latched on release");

        // 2F pressed during the ARRIVE cycle at 2F: set beats clear
        req_in = 6'b000010;
        @(negedge clk);
        req_in = 6'b0;
        wait_cmd(10);
        chk("s034_cmd_2f", 32'(cmd), 'h2);
        chk("s034_dir_down", 32'(cur_dir), 0);
        serve(2'd1);
        @(negedge clk);
        req_in = 6'b000010;
        @(negedge clk);
        req_in = 6'b0;
        chk("s034_set_wins", 32'(pending), 'h2);
        repeat (2) @(negedge clk);
        chk("s034_later_clear", 32'(pending), 0);
        $display("txn 034b: press during arrival kept pending");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
